// File: rtl/timer_control.sv
`default_nettype none
// ============================================================================
// Module  : timer_control
// Brief   : Stopwatch / countdown controller driving external h:m:s counters.
// Rev     : 1.0  initial release
// ============================================================================
module timer_control #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  input  logic       dir_sel,
  input  logic [5:0] sec_val,
  input  logic [5:0] min_val,
  input  logic [5:0] hr_val,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       forward,
  output logic       counter_clr,
  output logic       running,
  output logic       finish,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int              c_PRESC_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_TOP = c_PRESC_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [c_PRESC_W-1:0]   r_presc, w_presc_nxt;
  logic                   r_fwd, w_fwd_nxt;
  logic                   r_sec, r_min, r_hr;
  logic                   w_sec, w_min, w_hr;
  logic                   r_clr, w_clr;
  logic                   r_alarm;
  logic                   r_rst_pend;
  logic                   w_tick;
  logic                   w_all_zero;

  assign w_all_zero = (sec_val == 6'd0) && (min_val == 6'd0) && (hr_val == 6'd0);
  assign w_tick     = (r_state == S_RUN) && (r_presc == c_PRESC_TOP);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_fwd_nxt   = r_fwd;
    w_sec       = 1'b0;
    w_min       = 1'b0;
    w_hr        = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_presc_nxt = '0;
        if (clear_btn) begin
          w_clr = 1'b1;
        end else if (!stop_btn && start_btn && (dir_sel || !w_all_zero)) begin
          w_state_nxt = S_RUN;
          w_fwd_nxt   = dir_sel;
        end
      end
      S_RUN: begin
        // The prescaler keeps advancing on the stop cycle so a pause lands on a wrapped count.
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        if (clear_btn) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
          w_presc_nxt = '0;
        end else if (stop_btn) begin
          w_state_nxt = S_PAUSE;
        end else if (w_tick) begin
          if (r_fwd) begin
            w_sec = 1'b1;
            w_min = (sec_val == 6'd59);
            w_hr  = (sec_val == 6'd59) && (min_val == 6'd59);
          end else if (w_all_zero) begin
            w_state_nxt = S_DONE;
          end else begin
            w_sec = 1'b1;
            w_min = (sec_val == 6'd0) && ((min_val != 6'd0) || (hr_val != 6'd0));
            w_hr  = (sec_val == 6'd0) && (min_val == 6'd0) && (hr_val != 6'd0);
            if ((hr_val == 6'd0) && (min_val == 6'd0) && (sec_val == 6'd1)) begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_PAUSE: begin
        if (clear_btn) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
          w_presc_nxt = '0;
        end else if (!stop_btn && start_btn) begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (clear_btn || (!stop_btn && start_btn)) begin
          w_state_nxt = S_IDLE;
          w_clr       = 1'b1;
          w_presc_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_presc_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_fwd      <= 1'b1;
      r_sec      <= 1'b0;
      r_min      <= 1'b0;
      r_hr       <= 1'b0;
      r_clr      <= 1'b0;
      r_alarm    <= 1'b0;
      r_rst_pend <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_fwd      <= w_fwd_nxt;
      r_sec      <= w_sec;
      r_min      <= w_min;
      r_hr       <= w_hr;
      // Counters are also zeroed once on the first cycle out of reset.
      r_clr      <= w_clr | r_rst_pend;
      r_alarm    <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
      r_rst_pend <= 1'b0;
    end
  end

  assign sec_en      = r_sec;
  assign min_en      = r_min;
  assign hr_en       = r_hr;
  assign forward     = r_fwd;
  assign counter_clr = r_clr;
  assign alarm       = r_alarm;
  assign running     = (r_state == S_RUN);
  assign finish      = (r_state == S_DONE);
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_timer_control
// Brief   : Table-driven, scoreboarded bench for timer_control (TICK_DIV=4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_timer_control;

  logic       clk;
  logic       reset;
  logic       start_btn, stop_btn, clear_btn, dir_sel;
  logic [5:0] sec_val, min_val, hr_val;
  logic       sec_en, min_en, hr_en, forward, counter_clr, running, finish, alarm;
  logic [1:0] state;

  timer_control #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .start_btn(start_btn), .stop_btn(stop_btn), .clear_btn(clear_btn), .dir_sel(dir_sel),
    .sec_val(sec_val), .min_val(min_val), .hr_val(hr_val),
    .sec_en(sec_en), .min_en(min_en), .hr_en(hr_en),
    .forward(forward), .counter_clr(counter_clr),
    .running(running), .finish(finish), .alarm(alarm), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected word: {state, running, finish, alarm, counter_clr, forward, sec_en, min_en, hr_en}
  typedef struct {
    logic       rst, st, sp, cl, dir;
    logic [5:0] h, m, s;
    logic [9:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] sb[$];
  int         n_cmp;
  int         n_err;
  logic       r_done;

  function automatic logic [9:0] e(input logic [1:0] st, input logic alm, input logic clr,
                                   input logic fwd, input logic s, input logic m, input logic h);
    return {st, st == 2'd1, st == 2'd3, alm, clr, fwd, s, m, h};
  endfunction

  task automatic chk(input logic ok, input string msg);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic add(input logic rst, input logic st, input logic sp, input logic cl,
                     input logic dir, input logic [5:0] h, input logic [5:0] m,
                     input logic [5:0] s, input logic [9:0] exp);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.cl = cl; v.dir = dir;
    v.h = h; v.m = m; v.s = s; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Three quiet RUN cycles followed by the tick cycle's expected result.
  task automatic run4(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                      input logic fwd, input logic es, input logic em, input logic eh,
                      input logic [1:0] tst, input logic talm);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, h, m, s, e(2'd1, 0, 0, fwd, 0, 0, 0));
    add(0, 0, 0, 0, 0, h, m, s, e(tst, talm, 0, fwd, es, em, eh));
  endtask

  initial begin
    r_done = 1'b0;
    #200000;
    chk(r_done, "watchdog: vector run did not complete before the wait limit expired");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [9:0] got, want;
    vec_t v;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0; dir_sel = 1'b0;
    sec_val = '0; min_val = '0; hr_val = '0;

    // reset, then counter_clr on the first cycle out of reset; stop ignored in IDLE
    add(1, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0));
    add(1, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 1, 1, 0, 0, 0));
    add(0, 0, 1, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0));
    // stopwatch from zero; start ignored while running
    add(0, 1, 0, 0, 1, 0, 0, 0, e(1, 0, 0, 1, 0, 0, 0));
    add(0, 1, 0, 0, 0, 0, 0, 0, e(1, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, e(1, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, e(1, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, e(1, 0, 0, 1, 1, 0, 0));
    run4(0, 0, 0, 1, 1, 0, 0, 2'd1, 0);
    run4(5, 59, 59, 1, 1, 1, 1, 2'd1, 0);
    run4(23, 59, 59, 1, 1, 1, 1, 2'd1, 0);
    run4(0, 10, 59, 1, 1, 1, 0, 2'd1, 0);
    // clear beats stop
    add(0, 0, 1, 1, 0, 0, 0, 0, e(0, 0, 1, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0));
    // countdown start with all-zero values is refused
    add(0, 1, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0));
    // countdown from 0:0:2 into DONE
    add(0, 1, 0, 0, 0, 0, 0, 2, e(1, 0, 0, 0, 0, 0, 0));
    run4(0, 0, 2, 0, 1, 0, 0, 2'd1, 0);
    run4(0, 0, 1, 0, 1, 0, 0, 2'd3, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, e(3, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, 0, 0, 0, e(3, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 0, 0, 0, 0, 0, e(0, 0, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0));
    // countdown borrows, then pause on a tick and resume
    add(0, 1, 0, 0, 0, 0, 1, 0, e(1, 0, 0, 0, 0, 0, 0));
    run4(0, 1, 0, 0, 1, 1, 0, 2'd1, 0);
    run4(1, 0, 0, 0, 1, 1, 1, 2'd1, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, 0, 0, e(1, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, 1, 0, 0, e(2, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) add(0, 0, (k == 5), 0, 0, 1, 0, 0, e(2, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 0, 0, 1, 0, 0, e(1, 0, 0, 0, 0, 0, 0));
    run4(1, 0, 0, 0, 1, 1, 1, 2'd1, 0);
    // reset on a tick cycle suppresses the step
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, 0, 0, e(1, 0, 0, 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, 1, 0, 0, e(0, 0, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 1, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0));
    // countdown reaching all-zero at tick: DONE without a step
    add(0, 1, 0, 0, 0, 0, 0, 3, e(1, 0, 0, 0, 0, 0, 0));
    run4(0, 0, 0, 0, 0, 0, 0, 2'd3, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, e(3, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 1, 0, 0, 0, 0, e(0, 0, 1, 0, 0, 0, 0));
    // PAUSE: clear beats start
    add(0, 1, 0, 0, 1, 0, 0, 0, e(1, 0, 0, 1, 0, 0, 0));
    add(0, 0, 1, 0, 0, 0, 0, 0, e(2, 0, 0, 1, 0, 0, 0));
    add(0, 1, 0, 1, 0, 0, 0, 0, e(0, 0, 1, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0));

    @(negedge clk);
    chk((state === 2'd0) && (running === 1'b0) && (finish === 1'b0) && (alarm === 1'b0) &&
        (counter_clr === 1'b0) && (forward === 1'b1) &&
        (sec_en === 1'b0) && (min_en === 1'b0) && (hr_en === 1'b0),
        "reset state: outputs not at their reset values");
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      reset = v.rst; start_btn = v.st; stop_btn = v.sp; clear_btn = v.cl; dir_sel = v.dir;
      hr_val = v.h; min_val = v.m; sec_val = v.s;
      sb.push_back(v.exp);
      @(negedge clk);
      got  = {state, running, finish, alarm, counter_clr, forward, sec_en, min_en, hr_en};
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL vec%0d outputs {st,run,fin,alm,clr,fwd,s,m,h}: got %b want %b", i, got, want);
      end
    end
    r_done = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
